// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: fetches imem[pc_desp] over req/ack, hands it to decode over valid/ready,
// and produces the next PC for PC_reg. Optional feature macro: FETCH_MISALIGN_TRAP_EN.
module fetch_seq #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 32,
  parameter int PC_STEP = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    pc_desp,
  output logic [PC_W-1:0]    pc_antes,
  output logic               imem_req,
  output logic [PC_W-3:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               misalign_err,
  output logic [1:0]         state_dbg
);

  // Handshakes: imem transfer happens when imem_req & imem_ack; decode transfer when
  // instr_valid & instr_ready. Both producers hold their payload until the transfer.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_VALID = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    ipc_q, ipc_d;
  logic               misalign_q, misalign_d;
  logic               redir_bad;
  logic [PC_W-1:0]    redir_target;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redir_bad    = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign redir_target = redirect_pc;
`else
  assign redir_bad    = 1'b0;
  assign redir_target = {redirect_pc[PC_W-1:2], 2'b00};
`endif

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    ipc_d      = ipc_q;
    misalign_d = misalign_q;
    pc_antes   = pc_desp;
    case (state_q)
      S_IDLE:  if (!misalign_q) state_d = S_REQ;
      S_REQ: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          ipc_d   = pc_desp;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (instr_ready) begin
          pc_antes = pc_desp + PC_W'(PC_STEP);
          state_d  = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Redirect wins over everything; a same-cycle ack is dropped by keeping the old payload.
    if (redirect_valid && !misalign_q) begin
      instr_d = instr_q;
      ipc_d   = ipc_q;
      if (redir_bad) begin
        misalign_d = 1'b1;
        pc_antes   = pc_desp;
        state_d    = S_IDLE;
      end else begin
        pc_antes = redir_target;
        state_d  = S_REQ;
      end
    end
    if (rst) pc_antes = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      ipc_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      ipc_q      <= ipc_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_req     = (state_q == S_REQ);
  assign imem_addr    = pc_desp[PC_W-1:2];
  assign instr_valid  = (state_q == S_VALID);
  assign instr_out    = instr_q;
  assign instr_pc     = ipc_q;
  assign misalign_err = misalign_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq; a local register plays PC_reg (pc_desp <= pc_antes every cycle).
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  pc_desp;
  logic [9:0]  pc_antes;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [9:0]  instr_pc;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;
  logic        misalign_err;
  logic [1:0]  state_dbg;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  fetch_seq #(.PC_W(10), .INSTR_W(32), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .pc_desp(pc_desp), .pc_antes(pc_antes),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .instr_pc(instr_pc), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .misalign_err(misalign_err), .state_dbg(state_dbg)
  );

  // Clock / PC_reg
  always #5 clk = ~clk;
  always @(posedge clk) pc_desp <= pc_antes;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are checked in the low half of the clock.
  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) nxt();
    #1;
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_out", instr_out, 32'd0);
    chk("rst_ipc", 32'(instr_pc), 32'd0);
    chk("rst_pcn", 32'(pc_antes), 32'd0);
    chk("rst_mis", 32'(misalign_err), 32'd0);
    rst = 1'b0; #1;
    chk("idle_pcn", 32'(pc_antes), 32'd0);
    chk("idle_req", 32'(imem_req), 32'd0);

    // 1: ack in the same cycle as req, ready high
    nxt(); imem_ack = 1'b1; imem_rdata = 32'h00500093; instr_ready = 1'b1; #1;
    chk("t1_req", 32'(imem_req), 32'd1);
    chk("t1_addr", 32'(imem_addr), 32'h0);
    chk("t1_nvalid", 32'(instr_valid), 32'd0);
    nxt(); imem_ack = 1'b0; #1;
    chk("t1_valid", 32'(instr_valid), 32'd1);
    chk("t1_out", instr_out, 32'h00500093);
    chk("t1_ipc", 32'(instr_pc), 32'h0);
    chk("t1_pcn", 32'(pc_antes), 32'h4);
    chk("t1_noreq", 32'(imem_req), 32'd0);

    // 2: decode stalls for 5 cycles
    nxt(); instr_ready = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h11223344; #1;
    chk("t2_req", 32'(imem_req), 32'd1);
    chk("t2_addr", 32'(imem_addr), 32'h1);
    nxt(); imem_ack = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      chk("t2_valid", 32'(instr_valid), 32'd1);
      chk("t2_out", instr_out, 32'h11223344);
      chk("t2_ipc", 32'(instr_pc), 32'h4);
      chk("t2_pcn", 32'(pc_antes), 32'h4);
      chk("t2_noreq", 32'(imem_req), 32'd0);
      nxt(); #1;
    end
    instr_ready = 1'b1; #1;
    chk("t2_acc_pcn", 32'(pc_antes), 32'h8);
    nxt(); instr_ready = 1'b0; #1;
    chk("t2_single", 32'(instr_valid), 32'd0);

    // 3: ack delayed 3 cycles
    for (int i = 0; i < 3; i++) begin
      chk("t3_req", 32'(imem_req), 32'd1);
      chk("t3_addr", 32'(imem_addr), 32'h2);
      chk("t3_pcn", 32'(pc_antes), 32'h8);
      nxt(); #1;
    end
    imem_ack = 1'b1; imem_rdata = 32'hCAFEF00D; #1;
    chk("t3_req4", 32'(imem_req), 32'd1);
    nxt(); imem_ack = 1'b0; #1;
    chk("t3_out", instr_out, 32'hCAFEF00D);
    chk("t3_ipc", 32'(instr_pc), 32'h8);

    // 4a: redirect while holding a valid instruction
    redirect_valid = 1'b1; redirect_pc = 10'h100; #1;
    chk("t4a_pcn", 32'(pc_antes), 32'h100);
    nxt(); redirect_valid = 1'b0; #1;
    chk("t4a_flush", 32'(instr_valid), 32'd0);
    chk("t4a_addr", 32'(imem_addr), 32'h40);
    // 4b: redirect in S_REQ with ack in the same cycle
    redirect_valid = 1'b1; redirect_pc = 10'h100; imem_ack = 1'b1; imem_rdata = 32'hBADBAD00; #1;
    chk("t4b_pcn", 32'(pc_antes), 32'h100);
    nxt(); redirect_valid = 1'b0; imem_ack = 1'b0; #1;
    chk("t4b_drop_v", 32'(instr_valid), 32'd0);
    chk("t4b_drop_o", instr_out, 32'hCAFEF00D);
    chk("t4b_req", 32'(imem_req), 32'd1);
    chk("t4b_addr", 32'(imem_addr), 32'h40);
    imem_ack = 1'b1; imem_rdata = 32'h00000013; #1;
    nxt(); imem_ack = 1'b0; #1;
    chk("t4b_out", instr_out, 32'h00000013);
    chk("t4b_ipc", 32'(instr_pc), 32'h100);

    // 5: wrap at the top of the PC space
    redirect_valid = 1'b1; redirect_pc = 10'h3FC; #1;
    nxt(); redirect_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0000006F; #1;
    chk("t5_addr_top", 32'(imem_addr), 32'hFF);
    nxt(); imem_ack = 1'b0; instr_ready = 1'b1; #1;
    chk("t5_ipc", 32'(instr_pc), 32'h3FC);
    chk("t5_pcn", 32'(pc_antes), 32'h0);
    nxt(); instr_ready = 1'b0; #1;
    chk("t5_req", 32'(imem_req), 32'd1);
    chk("t5_addr", 32'(imem_addr), 32'h0);

    // 6: misaligned redirect target
    redirect_valid = 1'b1; redirect_pc = 10'h102; #1;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("t6_pcn", 32'(pc_antes), 32'h0);
    nxt(); redirect_valid = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("t6_mis", 32'(misalign_err), 32'd1);
      chk("t6_noreq", 32'(imem_req), 32'd0);
      chk("t6_state", 32'(state_dbg), 32'd0);
      nxt(); #1;
    end
`else
    chk("t6_pcn", 32'(pc_antes), 32'h100);
    nxt(); redirect_valid = 1'b0; #1;
    chk("t6_mis", 32'(misalign_err), 32'd0);
    chk("t6_req", 32'(imem_req), 32'd1);
    chk("t6_addr", 32'(imem_addr), 32'h40);
`endif

    // Reset mid-transaction clears everything
    rst = 1'b1; imem_ack = 1'b1; #1;
    chk("rst2_pcn", 32'(pc_antes), 32'h0);
    nxt(); imem_ack = 1'b0; #1;
    chk("rst2_state", 32'(state_dbg), 32'd0);
    chk("rst2_out", instr_out, 32'd0);
    chk("rst2_mis", 32'(misalign_err), 32'd0);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
